// File: rtl/sp_ram_pkg.sv
// Shared write-mode encodings and the byte-parity helper for the single-port byte-enable RAM.
package sp_ram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    // Even parity: the stored bit makes the byte plus parity bit contain an even number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sp_ram_outreg.sv
// Optional output stage for sp_ram_be: registers the read payload and its valid flag.
module sp_ram_outreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    input  logic         i_v,
    output logic [W-1:0] o_d,
    output logic         o_v
);

    logic [W-1:0] r_d;
    logic         r_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= '0;
            r_v <= 1'b0;
        end else begin
            r_v <= i_v;
            if (i_v) begin
                r_d <= i_d;
            end
        end
    end

    assign o_d = r_d;
    assign o_v = r_v;

endmodule

// File: rtl/sp_ram_be.sv
// Single-port RAM with byte enables, selectable write mode and optional output register.
// Define SP_RAM_PARITY_EN to store per-byte even parity and expose the parity_err port.
module sp_ram_be
    import sp_ram_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 16,
    parameter  int WRITE_MODE = WM_READ_FIRST,
    parameter  int OUT_REG    = 0,
    localparam int ADDR_W     = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int NB         = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid
`ifdef SP_RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef SP_RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    // The parity flag rides on top of the data word so the output stage stays generic.
    localparam int PW = WIDTH + PAR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_in_range;
    logic             w_capture;
    logic             w_wr;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_ret;
    logic [PW-1:0]    w_s1_next;
    logic [PW-1:0]    r_s1;
    logic             r_v1;
    logic [PW-1:0]    w_q;
    logic             w_v;

    assign w_in_range = {1'b0, addr} < DEPTH_L;
    assign w_old      = w_in_range ? r_mem[addr] : '0;
    assign w_wr       = !rst && en && we && w_in_range;
    assign w_capture  = en && !(we && (WRITE_MODE == WM_NO_CHANGE));

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                w_merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    assign w_ret = (we && (WRITE_MODE == WM_WRITE_FIRST)) ? (w_in_range ? w_merged : '0) : w_old;

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_par_old;
    logic [NB-1:0] w_par_merged;
    logic [NB-1:0] w_calc_old;
    logic [NB-1:0] w_calc_merged;
    logic          w_err;

    assign w_par_old = w_in_range ? r_par[addr] : '0;

    always_comb begin
        w_par_merged  = w_par_old;
        w_calc_old    = '0;
        w_calc_merged = '0;
        for (int i = 0; i < NB; i++) begin
            w_calc_old[i]    = byte_parity(w_old[8*i +: 8]);
            w_calc_merged[i] = byte_parity(w_merged[8*i +: 8]);
            if (be[i]) begin
                w_par_merged[i] = byte_parity(din[8*i +: 8]);
            end
        end
    end

    assign w_err = (we && (WRITE_MODE == WM_WRITE_FIRST)) ? |(w_calc_merged ^ w_par_merged)
                                                          : |(w_calc_old ^ w_par_old);
    assign w_s1_next = {w_err, w_ret};

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_par[addr] <= w_par_merged;
        end
    end
`else
    assign w_s1_next = w_ret;
`endif

    // Array has no reset; only the access path is squashed while rst is high.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[addr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_capture;
            if (w_capture) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    generate
        if (OUT_REG == 1) begin : g_outreg
            sp_ram_outreg #(.W(PW)) u_outreg (
                .clk (clk),
                .rst (rst),
                .i_d (r_s1),
                .i_v (r_v1),
                .o_d (w_q),
                .o_v (w_v)
            );
        end else begin : g_direct
            assign w_q = r_s1;
            assign w_v = r_v1;
        end
    endgenerate

    assign dout       = w_q[WIDTH-1:0];
    assign dout_valid = w_v;
`ifdef SP_RAM_PARITY_EN
    assign parity_err = w_q[PW-1] & w_v;
`endif

endmodule

// File: tb/tb_sp_ram_be.sv
// Scoreboard bench for sp_ram_be: three write modes with OUT_REG=0 plus a pipelined read-first instance.
module tb_sp_ram_be;

    typedef struct packed {
        logic        dc;
        logic        v;
        logic        pe;
        logic [15:0] d;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    logic        clk = 1'b0;
    logic        rst, en, we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [15:0] dout_m [4];
    logic [3:0]  dv_m;
`ifdef SP_RAM_PARITY_EN
    logic [3:0]  pe_m;
`endif

    always #5 clk = ~clk;

    sp_ram_be #(.WIDTH(16), .DEPTH(12), .WRITE_MODE(0), .OUT_REG(0)) u_m0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_m[0]), .dout_valid(dv_m[0])
`ifdef SP_RAM_PARITY_EN
        , .parity_err(pe_m[0])
`endif
    );
    sp_ram_be #(.WIDTH(16), .DEPTH(12), .WRITE_MODE(1), .OUT_REG(0)) u_m1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_m[1]), .dout_valid(dv_m[1])
`ifdef SP_RAM_PARITY_EN
        , .parity_err(pe_m[1])
`endif
    );
    sp_ram_be #(.WIDTH(16), .DEPTH(12), .WRITE_MODE(2), .OUT_REG(0)) u_m2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_m[2]), .dout_valid(dv_m[2])
`ifdef SP_RAM_PARITY_EN
        , .parity_err(pe_m[2])
`endif
    );
    sp_ram_be #(.WIDTH(16), .DEPTH(12), .WRITE_MODE(0), .OUT_REG(1)) u_p (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_m[3]), .dout_valid(dv_m[3])
`ifdef SP_RAM_PARITY_EN
        , .parity_err(pe_m[3])
`endif
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int n_step = 0;

    exp3_t q1 [$];
    exp_t  q2 [$];

    logic [15:0] mem_m     [12];
    logic [1:0]  bad_m     [12];
    logic        written_m [12];
    logic [15:0] last_m    [4];
    logic        last_dc   [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @step%0d: got %h, expected %h", tag, n_step, got, exp);
        end
    endtask

    task automatic sample();
        exp3_t x;
        exp_t  p;
        if (q1.size() == 0 || q2.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
            return;
        end
        x = q1.pop_front();
        p = q2.pop_front();
        for (int m = 0; m < 3; m++) begin
            check($sformatf("mode%0d_valid", m), {31'd0, dv_m[m]}, {31'd0, x[m].v});
            if (!x[m].dc) begin
                check($sformatf("mode%0d_dout", m), {16'd0, dout_m[m]}, {16'd0, x[m].d});
`ifdef SP_RAM_PARITY_EN
                check($sformatf("mode%0d_perr", m), {31'd0, pe_m[m]}, {31'd0, x[m].pe});
`endif
            end
        end
        check("pipe_valid", {31'd0, dv_m[3]}, {31'd0, p.v});
        if (!p.dc) begin
            check("pipe_dout", {16'd0, dout_m[3]}, {16'd0, p.d});
`ifdef SP_RAM_PARITY_EN
            check("pipe_perr", {31'd0, pe_m[3]}, {31'd0, p.pe});
`endif
        end
    endtask

    // Drive one access and push what each instance should show once its latency has elapsed.
    task automatic access(input logic r, input logic e, input logic w, input logic [1:0] b,
                          input logic [3:0] a, input logic [15:0] d);
        exp3_t       x;
        exp_t        p;
        logic        inr, known;
        logic [15:0] old, mrg;
        logic [1:0]  bd;
        rst = r; en = e; we = w; be = b; addr = a; din = d;
        x = '0;
        p = '0;
        inr   = (a < 4'd12);
        known = !inr || written_m[a];
        old   = inr ? mem_m[a] : 16'h0000;
        bd    = inr ? bad_m[a] : 2'b00;
        mrg   = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
        for (int m = 0; m < 4; m++) begin
            exp_t t;
            int   mode;
            t    = '0;
            mode = (m == 3) ? 0 : m;
            if (r) begin
                last_m[m]  = 16'h0000;
                last_dc[m] = 1'b0;
            end else if (e && !(w && mode == 2)) begin
                t.v = 1'b1;
                if (w && mode == 1) begin
                    t.d  = inr ? mrg : 16'h0000;
                    t.pe = |(bd & ~b);
                    t.dc = !known && (b != 2'b11);
                end else begin
                    t.d  = old;
                    t.pe = |bd;
                    t.dc = !known;
                end
                last_m[m]  = t.d;
                last_dc[m] = t.dc;
            end else begin
                t.d  = last_m[m];
                t.dc = last_dc[m];
            end
            if (m == 3) p = t;
            else        x[m] = t;
        end
        q1.push_back(x);
        if (r && q2.size() > 0) q2[q2.size()-1] = '0;
        q2.push_back(p);
        if (!r && e && w && inr) begin
            mem_m[a] = mrg;
            bad_m[a] = bd & ~b;
            if (b == 2'b11) written_m[a] = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic w, input logic [1:0] b,
                        input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        n_step++;
        sample();
        access(r, e, w, b, a, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b1, 1'b0, 2'b00, a, 16'h0000);
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] a, input logic [15:0] d);
        step(1'b0, 1'b1, 1'b1, b, a, d);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; be = 2'b00; addr = 4'd0; din = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            mem_m[i] = 16'h0000; bad_m[i] = 2'b00; written_m[i] = 1'b0;
        end
        for (int m = 0; m < 4; m++) begin
            last_m[m] = 16'h0000; last_dc[m] = 1'b0;
        end
        // Second stage has no prior access to describe, so seed it with its reset value.
        q2.push_back('0);
        @(negedge clk);
        access(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            wr(2'b11, 4'(i), (16'h0101 * 16'(i)) ^ 16'hC3A0);
        end

        wr(2'b11, 4'd3, 16'hABCD);
        wr(2'b01, 4'd3, 16'h1234);
        rd(4'd3);
        idle();

        wr(2'b11, 4'd5, 16'h1111);
        wr(2'b11, 4'd5, 16'h2222);
        rd(4'd5);
        idle();

        wr(2'b11, 4'd13, 16'hFFFF);
        rd(4'd13);
        rd(4'd1);
        idle();

        rd(4'd0); rd(4'd1); rd(4'd2);
        idle(); idle();
        rd(4'd0); rd(4'd1);
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
        idle(); idle();

        wr(2'b11, 4'd7, 16'h5A5A);
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
        rd(4'd7);
        idle();

        wr(2'b00, 4'd4, 16'hFFFF);
        rd(4'd4);
        step(1'b0, 1'b0, 1'b1, 2'b11, 4'd6, 16'hFFFF);
        rd(4'd6);
        step(1'b1, 1'b1, 1'b1, 2'b11, 4'd8, 16'hFFFF);
        rd(4'd8);
        idle();

`ifdef SP_RAM_PARITY_EN
        idle();
        u_m0.r_mem[2] = u_m0.r_mem[2] ^ 16'h0200;
        u_m1.r_mem[2] = u_m1.r_mem[2] ^ 16'h0200;
        u_m2.r_mem[2] = u_m2.r_mem[2] ^ 16'h0200;
        u_p.r_mem[2]  = u_p.r_mem[2]  ^ 16'h0200;
        mem_m[2]    = mem_m[2] ^ 16'h0200;
        bad_m[2][1] = ~bad_m[2][1];
        rd(4'd2);
        rd(4'd3);
        wr(2'b01, 4'd2, 16'h00EE);
        rd(4'd2);
        wr(2'b10, 4'd2, 16'h7700);
        rd(4'd2);
        idle();
`endif

        for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 16'($urandom));
        end
        idle(); idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_ram_be.md
SP_RAM_BE -- requirements
Module: sp_ram_be

Interface
REQ-001 Parameter WIDTH, default 8: data word width; SHALL be a multiple of 8, 8..64.
REQ-002 Parameter DEPTH, default 16: number of words, 2..4096; need not be a power of 2.
REQ-003 Parameter WRITE_MODE, default 0: 0 = read-first, 1 = write-first, 2 = no-change.
REQ-004 Parameter OUT_REG, default 0: 1 adds an output register stage.
REQ-005 Derived constants: ADDR_W = max(1, clog2(DEPTH)); NB = WIDTH/8.
REQ-006 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port en, input, 1: access enable; no access occurs when low.
REQ-009 Port we, input, 1: 1 = write, 0 = read (qualified by en).
REQ-010 Port be, input, NB: byte write enables; be[i] covers din[8i+7:8i].
REQ-011 Port addr, input, ADDR_W: word address.
REQ-012 Port din, input, WIDTH: write data.
REQ-013 Port dout, output, WIDTH: read data.
REQ-014 Port dout_valid, output, 1: dout carries the result of an access this cycle.
REQ-015 Port parity_err, output, 1: parity mismatch on the current dout; present only with SP_RAM_PARITY_EN.

Function
REQ-016 Write (en=1, we=1): each byte with be[i]=1 SHALL update at the edge; bytes with be[i]=0 SHALL be unchanged; be=0 is a no-op write.
REQ-017 Read (en=1, we=0): dout SHALL equal mem[addr] one cycle after the edge (OUT_REG=0) or two cycles after (OUT_REG=1); dout_valid SHALL be high in the same cycle.
REQ-018 Write with WRITE_MODE=0: dout SHALL return the old word at the read latency, with dout_valid=1.
REQ-019 Write with WRITE_MODE=1: dout SHALL return the new merged word (unenabled bytes keep old values), with dout_valid=1.
REQ-020 Write with WRITE_MODE=2: dout SHALL hold its previous value and dout_valid SHALL be 0.
REQ-021 en=0: dout SHALL hold and dout_valid SHALL be 0 at the corresponding latency.
REQ-022 addr >= DEPTH: a write SHALL be dropped; a read (or read-first/write-first return) SHALL give dout=0 with dout_valid=1.
REQ-023 Pipeline (OUT_REG=1): back-to-back accesses SHALL sustain one access per cycle, with results in issue order.
REQ-024 dout SHALL hold its last value whenever dout_valid=0.
REQ-025 Memory contents are undefined until written; there is no array initialisation.

Reset
REQ-026 rst=1 SHALL clear dout to 0, dout_valid to 0, parity_err to 0 and all pipeline stages at the next edge.
REQ-027 An access presented in a cycle with rst=1 SHALL be ignored: no write and no valid output.
REQ-028 Reset SHALL NOT alter memory contents; data written before reset SHALL read back after it.
REQ-029 rst asserted mid-pipeline (OUT_REG=1) SHALL squash the in-flight read; no dout_valid pulse follows.

Configuration
REQ-030 Macro SP_RAM_PARITY_EN defined: the array stores one even-parity bit per byte, computed at write; on a read, parity_err=1 in the dout_valid cycle if any byte mismatches.
REQ-031 On a partial write, parity SHALL be recomputed only for the enabled bytes.
REQ-032 Macro SP_RAM_PARITY_EN undefined: no parity storage and no parity_err port; all other behaviour is identical.

Structure
REQ-033 A shared package sp_ram_pkg SHALL hold the WRITE_MODE encodings (WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2) and the byte-parity function.
REQ-034 One sub-module, sp_ram_outreg, SHALL implement the optional output stage (data, valid, parity_err), instantiated only when OUT_REG=1.

Verification (WIDTH=16, DEPTH=12 unless stated)
REQ-035 Byte enables: write addr 3 with din=0xABCD, be=11; then din=0x1234, be=01; read addr 3 -> dout=0xAB34, dout_valid=1 one cycle later.
REQ-036 Write modes: mem[5]=0x1111; write 0x2222 (be=11) at addr 5 -> dout=0x1111 (mode 0), 0x2222 (mode 1), held with dout_valid=0 (mode 2).
REQ-037 Out of range: write 0xFFFF at addr 13, then read addr 13 -> dout=0x0000, dout_valid=1; mem[1] (addr alias) unchanged.
REQ-038 Pipeline (OUT_REG=1): reads of addrs 0,1,2 on consecutive cycles -> dout_valid high for 3 cycles starting 2 cycles after the first read, data in order; rst pulsed after the 2nd read -> no further valid.
REQ-039 Reset persistence: write 0x5A5A at addr 7, assert rst for 2 cycles -> dout=0 and dout_valid=0; then read addr 7 -> 0x5A5A.
REQ-040 Parity (SP_RAM_PARITY_EN): force-flip bit 9 of stored mem[2] via hierarchical deposit, then read addr 2 -> parity_err=1 alongside dout_valid; read an unmodified word -> parity_err=0.
